// File: rtl/unidade_controle_polilock.sv
// Polilock control unit: Moore FSM sequencing verify/program/lock over the 10-character
// password, tracking failed attempts and the open/blocked status.
module unidade_controle_polilock #(
  parameter bit GRAVA_REQUER_ABERTO = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] funcao,
  input  logic       funcao_selecionada,
  input  logic       igual,
  input  logic       fim_verificacao,
  input  logic       excedeu,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraT,
  output logic       contaT,
  output logic       escreve,
  output logic       pronto,
  output logic       aberto,
  output logic       bloqueado,
  output logic       erro_senha,
  output logic [3:0] db_estado
);

  // Bloqueio lives on the 5th bit so no 4-bit code is shared with it.
  typedef enum logic [4:0] {
    INICIAL    = 5'h00,
    PREPARACAO = 5'h01,
    ESPERA     = 5'h02,
    INI_VERIF  = 5'h03,
    AGUARDA_V  = 5'h04,
    COMPARA    = 5'h05,
    PROXIMO_V  = 5'h06,
    ACERTO     = 5'h07,
    ERRO       = 5'h08,
    CHECA      = 5'h09,
    INI_GRAV   = 5'h0A,
    AGUARDA_G  = 5'h0B,
    GRAVA      = 5'h0C,
    PROXIMO_G  = 5'h0D,
    FIM_GRAV   = 5'h0E,
    TRANCA     = 5'h0F,
    BLOQUEIO   = 5'h10
  } estado_t;

  typedef struct packed {
    logic       zera_c;
    logic       conta_c;
    logic       zera_t;
    logic       conta_t;
    logic       escreve;
    logic       pronto;
    logic       bloqueado;
    logic       erro_senha;
    logic [3:0] db_estado;
  } saidas_t;

  estado_t state_q, state_d;
  saidas_t saida_q, saida_d;
  logic    aberto_q, aberto_d;

  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    s.db_estado = e[3:0];
    case (e)
      PREPARACAO: begin
        s.zera_c = 1'b1;
        s.zera_t = 1'b1;
      end
      ESPERA:    s.pronto = 1'b1;
      INI_VERIF: s.zera_c = 1'b1;
      PROXIMO_V: s.conta_c = 1'b1;
      ACERTO:    s.zera_t = 1'b1;
      ERRO: begin
        s.conta_t    = 1'b1;
        s.erro_senha = 1'b1;
      end
      INI_GRAV:  s.zera_c = 1'b1;
      GRAVA:     s.escreve = 1'b1;
      PROXIMO_G: s.conta_c = 1'b1;
      FIM_GRAV:  s.zera_c = 1'b1;
      TRANCA:    s.zera_c = 1'b1;
      BLOQUEIO: begin
        s.bloqueado = 1'b1;
        s.db_estado = 4'hF;
      end
      default: s.db_estado = e[3:0];
    endcase
    return s;
  endfunction

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:    state_d = PREPARACAO;
      PREPARACAO: state_d = ESPERA;
      ESPERA: begin
        if (funcao_selecionada) begin
          case (funcao)
            2'b01: state_d = INI_VERIF;
            2'b10: begin
              if (!GRAVA_REQUER_ABERTO || aberto_q) begin
                state_d = INI_GRAV;
              end else begin
                state_d = ESPERA;
              end
            end
            2'b11:   state_d = TRANCA;
            default: state_d = ESPERA;
          endcase
        end else begin
          state_d = ESPERA;
        end
      end
      INI_VERIF: state_d = AGUARDA_V;
      AGUARDA_V: state_d = COMPARA;
      COMPARA: begin
        if (!igual) begin
          state_d = ERRO;
        end else if (fim_verificacao) begin
          state_d = ACERTO;
        end else begin
          state_d = PROXIMO_V;
        end
      end
      PROXIMO_V: state_d = AGUARDA_V;
      ACERTO:    state_d = ESPERA;
      ERRO:      state_d = CHECA;
      CHECA: begin
        if (excedeu) begin
          state_d = BLOQUEIO;
        end else begin
          state_d = ESPERA;
        end
      end
      INI_GRAV:  state_d = AGUARDA_G;
      AGUARDA_G: state_d = GRAVA;
      GRAVA: begin
        if (fim_verificacao) begin
          state_d = FIM_GRAV;
        end else begin
          state_d = PROXIMO_G;
        end
      end
      PROXIMO_G: state_d = AGUARDA_G;
      FIM_GRAV:  state_d = ESPERA;
      TRANCA:    state_d = ESPERA;
      BLOQUEIO:  state_d = BLOQUEIO;
      default:   state_d = INICIAL;
    endcase
  end

  // Open flag: set on a correct password, cleared by a lock request
  always_comb begin
    aberto_d = aberto_q;
    if (state_q == ACERTO) begin
      aberto_d = 1'b1;
    end else if (state_q == TRANCA) begin
      aberto_d = 1'b0;
    end else begin
      aberto_d = aberto_q;
    end
  end

  // Outputs are decoded from the next state so the registers line up with state_q
  always_comb begin
    saida_d = decodifica(state_d);
  end

  // State, decoded outputs and open flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INICIAL;
      saida_q  <= '0;
      aberto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      saida_q  <= saida_d;
      aberto_q <= aberto_d;
    end
  end

  assign zeraC      = saida_q.zera_c;
  assign contaC     = saida_q.conta_c;
  assign zeraT      = saida_q.zera_t;
  assign contaT     = saida_q.conta_t;
  assign escreve    = saida_q.escreve;
  assign pronto     = saida_q.pronto;
  assign bloqueado  = saida_q.bloqueado;
  assign erro_senha = saida_q.erro_senha;
  assign db_estado  = saida_q.db_estado;
  assign aberto     = aberto_q;

endmodule

// File: doc/unidade_controle_polilock.md
Name: unidade_controle_polilock

Overview:
Moore FSM that sequences the Polilock datapath: the address counter, the attempt counter, the reference-memory write enable and the serial/main memory comparison. It accepts a function request (verify, program, lock) and walks the 10-character password. It counts failed attempts, drives the unlocked and blocked status, and sits beside the datapath in the top level.

Parameters:
GRAVA_REQUER_ABERTO, 1, when 1 a program request is accepted only while aberto=1; when 0 it is always accepted.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; forces state inicial
funcao  in  2  requested function: 01 verify, 10 program, 11 lock, 00 none
funcao_selecionada  in  1  one-cycle pulse from datapath edge detector; funcao valid in the same cycle
igual  in  1  main memory word == serial memory word
fim_verificacao  in  1  address counter == 9
excedeu  in  1  attempt counter == max_tentativas
zeraC  out  1  clear address counter
contaC  out  1  increment address counter
zeraT  out  1  clear attempt counter
contaT  out  1  increment attempt counter
escreve  out  1  write enable of main memory
pronto  out  1  idle, waiting for a function
aberto  out  1  registered flag: lock open
bloqueado  out  1  high in terminal blocked state
erro_senha  out  1  one-cycle pulse on a wrong password
db_estado  out  4  current state code

Behaviour:
- Reset (synchronous, active-high) sets state=inicial and aberto=0. All outputs are 0 in inicial.
- Outputs are Moore-decoded from the state. Exception: aberto is a flag set in acerto and cleared in tranca or reset.
- Memories are synchronous read. After any address change, one wait state (aguarda) precedes any use of igual or write data.
- States, with codes:
  - inicial 0: go to preparacao.
  - preparacao 1: zeraC=1, zeraT=1; go to espera.
  - espera 2: pronto=1.
    - funcao_selecionada with 01: go to ini_verif.
    - With 10: go to ini_grav if GRAVA_REQUER_ABERTO=0 or aberto=1; otherwise stay in espera.
    - With 11: go to tranca.
    - With 00 or no pulse: stay.
  - ini_verif 3: zeraC=1; go to aguarda_v.
  - aguarda_v 4: go to compara.
  - compara 5:
    - igual=0: go to erro.
    - igual=1 and fim_verificacao=1: go to acerto.
    - Otherwise: go to proximo_v.
  - proximo_v 6: contaC=1; go to aguarda_v.
  - acerto 7: zeraT=1, set aberto; go to espera.
  - erro 8: contaT=1, erro_senha=1; go to checa.
  - checa 9: excedeu=1 goes to bloqueio; otherwise espera. The count is already updated here.
  - ini_grav A: zeraC=1; go to aguarda_g.
  - aguarda_g B: go to grava.
  - grava C: escreve=1.
    - fim_verificacao=1: go to fim_grav.
    - Otherwise: go to proximo_g.
  - proximo_g D: contaC=1; go to aguarda_g.
  - fim_grav E: zeraC=1; go to espera.
  - tranca F: clear aberto, zeraC=1; go to espera.
  - bloqueio (code 0 reused is forbidden): stays until reset, bloqueado=1. It is encoded by a 5th state bit internally, and db_estado reports 4'hF with bloqueado=1 to distinguish it from tranca.
- funcao_selecionada in any state other than espera is ignored and not queued.
- Verification reads addresses 0..9. The first mismatch aborts immediately, with no further address increments.
- Programming writes addresses 0..9 exactly once each. escreve and contaC are never high in the same cycle.
- A correct verification clears the attempt counter. A failed one never clears it.
- Reset mid-sequence aborts cleanly. The next cycle is inicial, then the counters are cleared in preparacao.
- zeraC and contaC are never asserted together; the same holds for zeraT and contaT.

Test Plan:
- Reset, then idle 3 cycles -> cycle 1 db_estado=0, then 1, then 2; pronto=1, aberto=0, zeraC=zeraT=1 only during state 1.
- Verify request, igual=1 for all 10 words -> exactly 9 contaC pulses, compara visited 10 times, acerto, aberto=1, zeraT pulse, back to espera in 32 cycles.
- Verify request, igual=0 at address 3 -> 3 contaC pulses, erro_senha pulse, contaT pulse, excedeu=0 returns to espera with aberto unchanged.
- max_tentativas=3: three failed verifies, excedeu=1 in the third checa -> bloqueado=1. Further funcao pulses are ignored; only reset recovers, after which state is 0.
- After an unlock, program request 10 -> escreve high in 10 non-consecutive cycles, with fim_verificacao=1 on the last. With GRAVA_REQUER_ABERTO=1 and aberto=0 the request is ignored.
- Lock request 11 while aberto=1 -> aberto=0 one cycle after tranca. A reset asserted during a program sequence at address 5 -> escreve=0 next cycle, state inicial.
